alib_points_stream_fifo: RTL and testbench

- Parametrised multi-channel point FIFO. It buffers CHANNELS fields of CH_WIDTH bits each per entry, e.g. 3x16 for h/v/r range-image points.
- Uses valid/ready handshakes on both sides. Supports non-power-of-two depths.
- Adds occupancy, almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between point decoders and range-image projection stages.
- Selectable output mode: first-word-fall-through or registered read.

---
 rtl/alib_points_stream_fifo_pkg.sv | 15 +
 rtl/alib_points_stream_fifo_wrap_ptr.sv | 29 ++
 rtl/alib_points_stream_fifo.sv | 148 ++++++++++++++
 tb/tb_alib_points_stream_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alib_points_stream_fifo_pkg.sv
// Shared definitions for the points stream FIFO: channel indices for
// h/v/r range-image points, the default field width and a slicing helper.
package alib_points_stream_fifo_pkg;

    localparam int CH_H         = 0;
    localparam int CH_V         = 1;
    localparam int CH_R         = 2;
    localparam int DEF_CH_WIDTH = 16;

    // LSB position of channel k inside a packed entry of w-bit fields.
    function automatic int ch_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/alib_points_stream_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with enable, synchronous flush and async active-low
// reset. Wraps by explicit compare so non-power-of-two depths work.
module alib_points_stream_fifo_wrap_ptr
    import alib_points_stream_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          en,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Advance by one per enable, returning to zero after the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (flush) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/alib_points_stream_fifo.sv
// Multi-channel point FIFO with valid/ready on both sides, occupancy and
// threshold flags, synchronous flush, sticky overflow/underflow, and a
// selectable first-word-fall-through or registered-read output.
module alib_points_stream_fifo
    import alib_points_stream_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int CHANNELS  = 3,
    parameter int CH_WIDTH  = DEF_CH_WIDTH,
    parameter int FWFT      = 1,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [CHANNELS*CH_WIDTH-1:0]   in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [CHANNELS*CH_WIDTH-1:0]   out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int DW = CHANNELS * CH_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;
    logic          read_underrun;

    // Status flags come straight from the count register.
    assign full         = (count == FULL_LEVEL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);
    assign in_ready     = !full;

    // Flush wins over any transfer in the same cycle.
    assign push          = in_valid && in_ready && !flush;
    assign read_underrun = (FWFT == 0) && out_ready && empty;

    alib_points_stream_fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_head_ptr (
        .clk   (clk),
        .rst_n (rst),
        .flush (flush),
        .en    (push),
        .ptr   (head)
    );

    alib_points_stream_fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst),
        .flush (flush),
        .en    (pop),
        .ptr   (tail)
    );

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[head] <= in_data;
        end
    end

    // Occupancy tracking at full width so DEPTH itself is representable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (read_underrun) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out_valid = !empty;
            assign out_data  = mem[tail];
            assign pop       = out_valid && out_ready && !flush;
        end else begin : g_reg_read
            logic [DW-1:0] rd_data;
            logic          rd_valid;

            assign pop       = out_ready && !empty && !flush;
            assign out_data  = rd_data;
            assign out_valid = rd_valid;

            // Registered read: one-cycle valid pulse, data held between reads.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else if (flush) begin
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= pop;
                    if (pop) begin
                        rd_data <= mem[tail];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_alib_points_stream_fifo.sv
// Directed bench for alib_points_stream_fifo: a 16-deep FWFT instance, a
// 5-deep FWFT instance for wrap-around, and a 4-deep registered-read instance.
module tb_alib_points_stream_fifo;

    localparam int DW = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic          a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [4:0]    a_count;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic          b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [2:0]    b_count;

    logic          c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic          c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
    logic [DW-1:0] c_in_data, c_out_data;
    logic [2:0]    c_count;

    alib_points_stream_fifo #(
        .DEPTH(16), .CHANNELS(3), .CH_WIDTH(16), .FWFT(1), .AF_MARGIN(2), .AE_MARGIN(2)
    ) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .count(a_count), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf), .underflow(a_unf)
    );

    alib_points_stream_fifo #(
        .DEPTH(5), .CHANNELS(3), .CH_WIDTH(16), .FWFT(1), .AF_MARGIN(2), .AE_MARGIN(2)
    ) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .count(b_count), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf), .underflow(b_unf)
    );

    alib_points_stream_fifo #(
        .DEPTH(4), .CHANNELS(3), .CH_WIDTH(16), .FWFT(0), .AF_MARGIN(1), .AE_MARGIN(1)
    ) u_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .count(c_count), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .overflow(c_ovf), .underflow(c_unf)
    );

    function automatic logic [DW-1:0] pt(input int h, input int v, input int r);
        return {16'(r), 16'(v), 16'(h)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
        c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_in_data = '0;
        tick();
        tick();

        // Reset state
        check("rst_count", 64'(a_count), 0);
        check("rst_empty", 64'(a_empty), 1);
        check("rst_full", 64'(a_full), 0);
        check("rst_ae", 64'(a_ae), 1);
        check("rst_in_ready", 64'(a_in_ready), 1);
        check("rst_ovf", 64'(a_ovf), 0);
        check("rst_c_out_valid", 64'(c_out_valid), 0);
        check("rst_c_out_data", 64'(c_out_data), 0);
        rst = 1'b1;
        tick();

        // Fill A to DEPTH
        for (int i = 0; i < 16; i++) begin
            a_in_data  = pt(i, i + 100, i + 200);
            a_in_valid = 1'b1;
            tick();
            check("fill_count", 64'(a_count), 64'(i + 1));
            check("fill_af", 64'(a_af), 64'((i + 1) >= 14));
        end
        check("fill_full", 64'(a_full), 1);
        check("fill_in_ready", 64'(a_in_ready), 0);
        a_in_data = pt(99, 99, 99);
        tick();
        a_in_valid = 1'b0;
        check("ovf_set", 64'(a_ovf), 1);
        check("ovf_count", 64'(a_count), 16);

        // Drain A in FWFT order
        a_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", 64'(a_out_valid), 1);
            check("drain_data", 64'(a_out_data), 64'(pt(i, i + 100, i + 200)));
            check("drain_ae", 64'(a_ae), 64'((16 - i) <= 2));
            tick();
        end
        a_out_ready = 1'b0;
        check("drain_empty", 64'(a_empty), 1);
        check("drain_count", 64'(a_count), 0);
        check("drain_out_valid", 64'(a_out_valid), 0);

        // Push+pop while empty: only the push happens, no bypass
        a_in_data = pt(16'h11, 1, 2);
        a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        check("sim0_valid_pre", 64'(a_out_valid), 0);
        tick();
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        check("sim0_count", 64'(a_count), 1);
        check("sim0_valid_post", 64'(a_out_valid), 1);
        check("sim0_data", 64'(a_out_data), 64'(pt(16'h11, 1, 2)));
        for (int k = 2; k <= 3; k++) begin
            a_in_data = pt(k * 16'h11, 1, 2);
            a_in_valid = 1'b1;
            tick();
        end
        a_in_valid = 1'b0;
        check("sim3_count_pre", 64'(a_count), 3);

        // Push+pop at count 3
        a_in_data = pt(16'h44, 1, 2);
        a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        check("sim3_count", 64'(a_count), 3);
        check("sim3_head", 64'(a_out_data), 64'(pt(16'h22, 1, 2)));

        // Flush at count 7 with a concurrent push
        for (int k = 0; k < 4; k++) begin
            a_in_data = pt(16'h55 + k, 0, 0);
            a_in_valid = 1'b1;
            tick();
        end
        check("flush_count_pre", 64'(a_count), 7);
        a_flush = 1'b1;
        a_in_data = pt(16'h77, 0, 0);
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        check("flush_count", 64'(a_count), 0);
        check("flush_empty", 64'(a_empty), 1);
        check("flush_ovf", 64'(a_ovf), 0);
        check("flush_out_valid", 64'(a_out_valid), 0);
        check("flush_in_ready", 64'(a_in_ready), 1);

        // Push+pop at full: pop happens, push rejected
        for (int j = 0; j < 16; j++) begin
            a_in_data = pt(j, j + 100, j + 200);
            a_in_valid = 1'b1;
            tick();
        end
        check("simf_full_pre", 64'(a_full), 1);
        a_in_data = pt(16'hEE, 0, 0);
        a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        check("simf_count", 64'(a_count), 15);
        check("simf_ovf", 64'(a_ovf), 1);
        check("simf_head", 64'(a_out_data), 64'(pt(1, 101, 201)));

        // Wrap-around with DEPTH=5
        for (int k = 1; k <= 3; k++) begin
            b_in_data = pt(k, 0, 0);
            b_in_valid = 1'b1;
            tick();
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check("wrap_pop1_data", 64'(b_out_data), 64'(pt(k, 0, 0)));
            tick();
        end
        b_out_ready = 1'b0;
        check("wrap_empty1", 64'(b_empty), 1);
        for (int k = 0; k < 5; k++) begin
            b_in_data = pt(10 + k, 20 + k, 30 + k);
            b_in_valid = 1'b1;
            tick();
            check("wrap_count", 64'(b_count), 64'(k + 1));
        end
        b_in_valid = 1'b0;
        check("wrap_full", 64'(b_full), 1);
        b_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("wrap_pop2_data", 64'(b_out_data), 64'(pt(10 + k, 20 + k, 30 + k)));
            tick();
        end
        b_out_ready = 1'b0;
        check("wrap_empty2", 64'(b_empty), 1);

        // Registered read: underflow on empty read
        c_out_ready = 1'b1;
        tick();
        c_out_ready = 1'b0;
        check("unf_set", 64'(c_unf), 1);
        check("unf_count", 64'(c_count), 0);
        check("unf_out_valid", 64'(c_out_valid), 0);

        c_in_data = pt(16'h00AA, 1, 2);
        c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        check("rd_count_pre", 64'(c_count), 1);
        check("rd_valid_pre", 64'(c_out_valid), 0);
        c_out_ready = 1'b1;
        tick();
        c_out_ready = 1'b0;
        check("rd_valid", 64'(c_out_valid), 1);
        check("rd_data", 64'(c_out_data), 64'(pt(16'h00AA, 1, 2)));
        check("rd_count", 64'(c_count), 0);
        tick();
        check("rd_valid_pulse", 64'(c_out_valid), 0);
        check("rd_data_hold", 64'(c_out_data), 64'(pt(16'h00AA, 1, 2)));

        // Flush in registered mode: valid drops, data held, underflow clears
        c_in_data = pt(16'h55, 3, 4);
        c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        c_out_ready = 1'b1;
        tick();
        c_out_ready = 1'b0;
        check("rdf_valid_pre", 64'(c_out_valid), 1);
        c_flush = 1'b1;
        tick();
        c_flush = 1'b0;
        check("rdf_valid", 64'(c_out_valid), 0);
        check("rdf_data_hold", 64'(c_out_data), 64'(pt(16'h55, 3, 4)));
        check("rdf_unf", 64'(c_unf), 0);

        // Asynchronous reset mid-burst
        a_in_data = pt(16'hBB, 0, 0);
        a_in_valid = 1'b1;
        tick();
        check("arst_count_pre", 64'(a_count), 16);
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", 64'(a_count), 0);
        check("arst_empty", 64'(a_empty), 1);
        check("arst_ovf", 64'(a_ovf), 0);
        check("arst_in_ready", 64'(a_in_ready), 1);
        a_in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
